nibble_serial_add: RTL and testbench
====================================

Name: nibble_serial_add

Overview:
- Multi-cycle WIDTH-bit adder that sits directly upstream of the team's fulladd_4bit.
- Latches a wide operand pair plus carry-in, then feeds fulladd_4bit one nibble per clock, least-significant nibble first.
- Chains the carry through a register and assembles the full sum.
- Result is presented on a valid/ready output handshake, so wide adds reuse one 4-bit adder instead of a ripple chain.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 8.
- NIBBLES, WIDTH/4, derived localparam; number of RUN cycles per add.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c_in  in  1  carry into bit 0.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- sum  out  WIDTH  A+B+c_in, low WIDTH bits.
- carry  out  1  carry out of bit WIDTH-1.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, nibble index=0, carry register=0, sum=0, carry=0, out_valid=0, in_ready=1. All operand registers are cleared.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready at an edge, capture a, b, c_in (c_in loads the carry register), index=0, go to RUN.
  - RUN: in_ready=0. Each edge drives nibble[index] of A and B plus the carry register into fulladd_4bit. The 4-bit result is written into sum[4*index+:4] and the carry register takes the adder's carry. index increments. At index==NIBBLES-1, go to DONE.
  - DONE: out_valid=1, in_ready=0. sum and carry (= carry register) are held stable. On out_ready, go to IDLE; out_valid drops after that edge.
- Latency: with acceptance at edge k, out_valid is high after edge k+NIBBLES (WIDTH=16: after k+4).
- Throughput: one add per NIBBLES+2 cycles minimum. IDLE is always visited between operations; no accept in the same cycle as result consumption.
- in_valid while busy (RUN/DONE) is ignored. The operands are not captured and no error is flagged; the upstream must hold in_valid until in_ready.
- Back-pressure: sum and carry must not change while out_valid=1 and out_ready=0.
- sum holds the last result after returning to IDLE until the next RUN overwrites it nibble by nibble. Consumers use it only under out_valid.
- Arithmetic is unsigned modulo 2^WIDTH, with carry as bit WIDTH. It must equal {carry,sum} = a+b+c_in exactly, including the all-ones wrap.
- rst_n asserted mid-RUN or in DONE aborts immediately to the reset values; the partial result is discarded.
- out_ready while not in DONE has no effect.

Optional Feature:
- Macro: NIBBLE_SERIAL_OVF_EN.
- Defined: adds output port ovf (1 bit) = two's-complement signed overflow of the WIDTH-bit add, i.e. carry into the MSB XOR carry out of the MSB. It is computed from the final nibble, valid with out_valid, and reset to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package nsa_pkg:
  - state enum (IDLE, RUN, DONE) as a 2-bit type.
  - NIB_W=4 constant.
  - Helper function for the nibble count from WIDTH.
- One sub-module: instantiate the existing fulladd_4bit (ports a, b, c_in, sum, carry) as the nibble datapath.
- Index counter, carry register and FSM stay in this module.

Test Plan:
- a=16'hFFFF, b=16'h0001, c_in=0 -> sum=16'h0000, carry=1, out_valid high exactly 4 cycles after accept; ovf=0 when the macro is defined.
- a=16'h1234, b=16'h4321, c_in=1 -> sum=16'h5556, carry=0.
- a=16'hA5A5, b=16'h5A5A, c_in=1 with out_ready held low 3 cycles in DONE -> sum=16'h0000, carry=1, stable all 3 cycles; in_ready stays 0; new in_valid pulses ignored.
- Second operand pair (16'h00FF+16'h0001, c_in=0) presented during RUN of a first add -> first result correct; second accepted only after return to IDLE; sum=16'h0100, carry=0.
- rst_n pulsed low after 2 RUN cycles -> out_valid=0, sum=0, carry=0, in_ready=1 asynchronously. A following add 16'h0003+16'h0004 returns 16'h0007.
- With NIBBLE_SERIAL_OVF_EN defined: 16'h7FFF+16'h0001, c_in=0 -> sum=16'h8000, carry=0, ovf=1; 16'h8000+16'h8000 -> sum=16'h0000, carry=1, ovf=1.

Source files
------------

// File: rtl/nsa_pkg.sv
// rtl/nsa_pkg.sv - shared state type, nibble width and nibble-count helper for nibble_serial_add
package nsa_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int nibble_count(input int width);
      return width / NIB_W;
   endfunction

endpackage

// File: rtl/fulladd_4bit.sv
// rtl/fulladd_4bit.sv - 4-bit adder with carry-in and carry-out
module fulladd_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c_in,
   output logic [3:0] sum,
   output logic       carry
);

   assign {carry, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};

endmodule

// File: rtl/nibble_serial_add.sv
// rtl/nibble_serial_add.sv - WIDTH-bit adder feeding fulladd_4bit one nibble per clock; NIBBLE_SERIAL_OVF_EN adds signed overflow output
module nibble_serial_add
   import nsa_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry
`ifdef NIBBLE_SERIAL_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NIBBLES = nibble_count(WIDTH);
   localparam int IDX_W   = $clog2(NIBBLES);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q;
   logic               carry_q;
   logic [WIDTH-1:0]   a_q, b_q, sum_q;
   logic [NIB_W-1:0]   nib_a, nib_b, fa_sum;
   logic               fa_carry;
   logic               last_nib;

   assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));
   assign nib_a    = a_q[idx_q*NIB_W +: NIB_W];
   assign nib_b    = b_q[idx_q*NIB_W +: NIB_W];

   fulladd_4bit u_fa (
      .a     (nib_a),
      .b     (nib_b),
      .c_in  (carry_q),
      .sum   (fa_sum),
      .carry (fa_carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            if (last_nib) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // sum is only written in RUN, so it holds through DONE and the following IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  carry_q <= c_in;
                  idx_q   <= '0;
               end
            end
            RUN: begin
               sum_q[idx_q*NIB_W +: NIB_W] <= fa_sum;
               carry_q                     <= fa_carry;
               idx_q                       <= last_nib ? '0 : idx_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign sum   = sum_q;
   assign carry = carry_q;

`ifdef NIBBLE_SERIAL_OVF_EN
   logic ovf_q;

   // carry into the MSB is recovered from the MSB sum bit: c = a ^ b ^ s
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (state_q == RUN && last_nib) begin
         ovf_q <= (nib_a[NIB_W-1] ^ nib_b[NIB_W-1] ^ fa_sum[NIB_W-1]) ^ fa_carry;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_add.sv
// tb/tb_nibble_serial_add.sv - self-checking bench for nibble_serial_add (WIDTH=16)
module tb_nibble_serial_add;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a, b;
   logic        c_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        carry;
`ifdef NIBBLE_SERIAL_OVF_EN
   logic        ovf;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   nibble_serial_add #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry     (carry)
`ifdef NIBBLE_SERIAL_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] va;
      logic [15:0] vb;
      logic        vc;
      logic [15:0] es;
      logic        ec;
      logic        eo;
      int          hold;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, " latency"}, n, 4);
   endtask

   task automatic consume(input string tag, input logic [15:0] es);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, " out_valid drop"}, out_valid, 1'b0);
      check({tag, " in_ready back"}, in_ready, 1'b1);
      check({tag, " sum held in idle"}, sum, es);
   endtask

   task automatic run_add(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                          input int hold, input logic [15:0] es, input logic ec,
                          input logic eo, input string tag);
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, " in_ready before accept"}, in_ready, 1'b1);
      a = va;
      b = vb;
      c_in = vc;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check({tag, " in_ready in run"}, in_ready, 1'b0);
      wait_done(tag);
      check({tag, " sum"}, sum, es);
      check({tag, " carry"}, carry, ec);
`ifdef NIBBLE_SERIAL_OVF_EN
      check({tag, " ovf"}, ovf, eo);
`endif
      for (int i = 0; i < hold; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         in_valid = (i % 2 == 0);
         @(posedge clk);
         #1;
         check({tag, " hold out_valid"}, out_valid, 1'b1);
         check({tag, " hold in_ready"}, in_ready, 1'b0);
         check({tag, " hold sum"}, sum, es);
         check({tag, " hold carry"}, carry, ec);
      end
      in_valid = 1'b0;
      consume(tag, es);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [16:0] ref_full;
      logic        ref_ovf;
      logic [15:0] ra, rb;
      logic        rc;

      vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0};
      vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 0};
      vecs[2] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0, 3};
      vecs[3] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 0};
      vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0};
      vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1};
      vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0};

      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      c_in = 1'b0;
      #1;
      check("reset in_ready", in_ready, 1'b1);
      check("reset out_valid", out_valid, 1'b0);
      check("reset sum", sum, 16'h0000);
      check("reset carry", carry, 1'b0);
`ifdef NIBBLE_SERIAL_OVF_EN
      check("reset ovf", ovf, 1'b0);
`endif
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 7; i++) begin
         run_add(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].hold,
                 vecs[i].es, vecs[i].ec, vecs[i].eo, $sformatf("vec%0d", i));
      end

      // second operand pair held on in_valid during the first add
      a = 16'h1111;
      b = 16'h2222;
      c_in = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      a = 16'h00FF;
      b = 16'h0001;
      check("overlap in_ready in run", in_ready, 1'b0);
      wait_done("overlap first");
      check("overlap first sum", sum, 16'h3333);
      check("overlap first carry", carry, 1'b0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("overlap idle out_valid", out_valid, 1'b0);
      check("overlap idle in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("overlap second accepted", in_ready, 1'b0);
      wait_done("overlap second");
      check("overlap second sum", sum, 16'h0100);
      check("overlap second carry", carry, 1'b0);
      consume("overlap second", 16'h0100);

      // reset asserted after two RUN cycles
      a = 16'hFFFF;
      b = 16'hFFFF;
      c_in = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort out_valid", out_valid, 1'b0);
      check("abort sum", sum, 16'h0000);
      check("abort carry", carry, 1'b0);
      check("abort in_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_add(16'h0003, 16'h0004, 1'b0, 0, 16'h0007, 1'b0, 1'b0, "after abort");

      for (int i = 0; i < 40; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         if (i == 0) begin
            ra = 16'hFFFF;
            rb = 16'h0000;
            rc = 1'b1;
         end
         ref_full = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
         ref_ovf  = (ra[15] == rb[15]) && (ref_full[15] != ra[15]);
         run_add(ra, rb, rc, int'($urandom_range(0, 2)), ref_full[15:0], ref_full[16],
                 ref_ovf, $sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
